// File: rtl/rv32_btn_debounce.sv
// rtl/rv32_btn_debounce.sv - push-button synchronizer, debouncer, edge pulses and press counter
// A new level is accepted only after DB_CYCLES consecutive synchronized samples disagree with btn_free.
module rv32_btn_debounce #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_free,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [7:0] btn_count
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             free_q, free_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       count_q, count_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          rise_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE_LO;
    endcase
    // btn_free is a flop of the decoded next state so it lands with the pulse.
    free_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      free_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      free_q  <= free_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign btn_free  = free_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign btn_count = count_q;

endmodule
